gate_truth_table_checker: RTL
=============================

// Module: gate_truth_table_checker
// PURPOSE
//  Drives an N_IN-input gate DUT through every input vector, 0 to 2**N_IN-1.
//  Waits SETTLE cycles after each vector, samples the DUT output and compares it
//  against an expected truth table. Reports pass/fail, mismatch count, first
//  failing vector and the captured truth table.
//  Sits beside the gate-level models as their on-chip stimulus/response end.
// PARAMETERS
//  N_IN     2        number of DUT inputs, legal 1..8
//  SETTLE   2        cycles drv is held before sampling, legal >=1
//  EXP_TT   4'b1000  expected table, width 2**N_IN; bit i = expected y for drv==i (AND)
// PORTS
//  clk              in   1          rising-edge clock
//  rst              in   1          asynchronous reset, active-high
//  start            in   1          begin a sweep; honoured only in IDLE
//  drv              out  N_IN       input vector driven to the DUT
//  y_in             in   1          DUT output; same clock domain, no synchroniser
//  busy             out  1          sweep in progress
//  done             out  1          one-cycle pulse at end of sweep
//  pass             out  1          1 = zero mismatches; held until next start
//  fail_cnt         out  N_IN+1     number of mismatching vectors
//  first_fail_idx   out  N_IN       lowest failing vector index; 0 if none
//  captured_tt      out  2**N_IN    bit i = y_in sampled for vector i
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; drv, busy, done, pass, fail_cnt,
//    first_fail_idx, captured_tt and the internal idx/cnt all = 0.
//    Reset mid-sweep aborts it; no done pulse is produced.
//  - FSM states: IDLE, WAIT, SAMPLE, DONE. All outputs are registered.
//  - IDLE: busy=0. On start=1 at a clock edge:
//    clear fail_cnt, first_fail_idx, captured_tt and pass; set idx=0, drv=0, cnt=0;
//    go to WAIT.
//  - WAIT: busy=1; cnt increments each cycle. On the edge where cnt==SETTLE-1, go to SAMPLE.
//    drv is therefore stable for SETTLE full cycles plus the SAMPLE cycle.
//  - SAMPLE: busy=1. At the closing edge:
//    captured_tt[idx] <= y_in.
//    On mismatch with EXP_TT[idx]: fail_cnt++, and first_fail_idx <= idx if fail_cnt==0.
//    If idx==2**N_IN-1, go to DONE; otherwise idx++, drv<=idx+1, cnt<=0, go to WAIT.
//  - DONE: busy=1 and done=1 for exactly one cycle; pass <= (final fail_cnt==0);
//    go to IDLE. drv holds its last value until the next start.
//  - Latency: taking the start-sampling edge as edge 0, done is high in the cycle
//    after edge 2**N_IN*(SETTLE+1).
//  - start while busy (WAIT/SAMPLE/DONE) is ignored. start held high re-launches
//    on the first IDLE edge after DONE.
//  - fail_cnt cannot overflow: its maximum value 2**N_IN fits in N_IN+1 bits.
//  - A registered DUT with 1-cycle latency is still sampled correctly for SETTLE>=1.
// CONFIGURATION
//  STUCK_DETECT_EN defined: adds output port stuck (1 bit, reset 0).
//    Updated at the DONE edge: stuck = 1 if captured_tt is all-0 or all-1, else 0.
//    Held until the next start, which clears it.
//  STUCK_DETECT_EN undefined: no stuck port and no associated logic.
//    All other behaviour is identical.
// TESTING (N_IN=2, SETTLE=2, EXP_TT=4'b1000 unless stated)
//  1 y_in=&drv, pulse start -> done at edge 12 after start; pass=1, fail_cnt=0,
//    captured_tt=4'b1000; drv sequence 0,1,2,3, each value held 3 cycles.
//  2 y_in=|drv -> pass=0, fail_cnt=2, first_fail_idx=1, captured_tt=4'b1110.
//  3 y_in=0 -> fail_cnt=1, first_fail_idx=3, captured_tt=4'b0000.
//    With STUCK_DETECT_EN: stuck=1. With y_in=&drv: stuck=0.
//  4 y_in=&drv, extra start pulses while idx==2 and during DONE -> ignored;
//    single done pulse; results identical to test 1.
//  5 rst pulsed while drv==2 -> immediately drv=0, busy=0, fail_cnt=0, pass=0,
//    no done pulse. A subsequent start completes exactly as test 1.
//  6 Run test 2 then immediately test 1 (start in the cycle after done) ->
//    counters cleared at start; final pass=1, fail_cnt=0, first_fail_idx=0.

Source files
------------

// File: rtl/gate_truth_table_checker.sv
// Exhaustive stimulus/response checker for an N_IN-input combinational or registered gate.
// Optional `STUCK_DETECT_EN adds a stuck output flagging an all-0 / all-1 captured table.
module gate_truth_table_checker #(
   parameter int                      N_IN   = 2,
   parameter int                      SETTLE = 2,
   parameter logic [(1<<N_IN)-1:0]    EXP_TT = 4'b1000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   output logic [N_IN-1:0]        drv,
   input  logic                   y_in,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic [N_IN:0]          fail_cnt,
   output logic [N_IN-1:0]        first_fail_idx,
   output logic [(1<<N_IN)-1:0]   captured_tt
`ifdef STUCK_DETECT_EN
   ,
   output logic                   stuck
`endif
);

   localparam int NV = 1 << N_IN;
   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   localparam logic [CW-1:0]   LAST_CNT = CW'(SETTLE - 1);
   localparam logic [CW-1:0]   ONE_C    = 1;
   localparam logic [N_IN-1:0] LAST_IDX = '1;
   localparam logic [N_IN-1:0] ONE_I    = 1;
   localparam logic [N_IN:0]   ONE_F    = 1;
   localparam logic [NV-1:0]   ALL_ONE  = '1;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      SAMPLE,
      DONE
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [N_IN-1:0]   idx;
   logic [N_IN-1:0]   idx_nxt;
   logic [CW-1:0]     cnt;
   logic [CW-1:0]     cnt_nxt;
   logic [N_IN-1:0]   drv_nxt;
   logic              busy_nxt;
   logic              done_nxt;
   logic              pass_nxt;
   logic [N_IN:0]     fail_nxt;
   logic [N_IN-1:0]   first_nxt;
   logic [NV-1:0]     cap_nxt;
`ifdef STUCK_DETECT_EN
   logic              stuck_nxt;
`endif

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      cnt_nxt   = cnt;
      drv_nxt   = drv;
      done_nxt  = 1'b0;
      pass_nxt  = pass;
      fail_nxt  = fail_cnt;
      first_nxt = first_fail_idx;
      cap_nxt   = captured_tt;
`ifdef STUCK_DETECT_EN
      stuck_nxt = stuck;
`endif
      unique case (state)
         IDLE: begin
            if (start) begin
               fail_nxt  = '0;
               first_nxt = '0;
               cap_nxt   = '0;
               pass_nxt  = 1'b0;
               idx_nxt   = '0;
               drv_nxt   = '0;
               cnt_nxt   = '0;
`ifdef STUCK_DETECT_EN
               stuck_nxt = 1'b0;
`endif
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            cnt_nxt = cnt + ONE_C;
            if (cnt == LAST_CNT) begin
               state_nxt = SAMPLE;
            end
         end
         SAMPLE: begin
            cap_nxt[idx] = y_in;
            if (y_in != EXP_TT[idx]) begin
               fail_nxt = fail_cnt + ONE_F;
               if (fail_cnt == '0) begin
                  first_nxt = idx;
               end
            end
            if (idx == LAST_IDX) begin
               state_nxt = DONE;
               done_nxt  = 1'b1;
            end else begin
               idx_nxt   = idx + ONE_I;
               drv_nxt   = idx + ONE_I;
               cnt_nxt   = '0;
               state_nxt = WAIT;
            end
         end
         DONE: begin
            // fail_cnt and captured_tt are final by the time DONE is entered
            pass_nxt  = (fail_cnt == '0);
`ifdef STUCK_DETECT_EN
            stuck_nxt = (captured_tt == '0) ||
                        (captured_tt == ALL_ONE);
`endif
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      busy_nxt = (state_nxt != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         idx            <= '0;
         cnt            <= '0;
         drv            <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         fail_cnt       <= '0;
         first_fail_idx <= '0;
         captured_tt    <= '0;
`ifdef STUCK_DETECT_EN
         stuck          <= 1'b0;
`endif
      end else begin
         state          <= state_nxt;
         idx            <= idx_nxt;
         cnt            <= cnt_nxt;
         drv            <= drv_nxt;
         busy           <= busy_nxt;
         done           <= done_nxt;
         pass           <= pass_nxt;
         fail_cnt       <= fail_nxt;
         first_fail_idx <= first_nxt;
         captured_tt    <= cap_nxt;
`ifdef STUCK_DETECT_EN
         stuck          <= stuck_nxt;
`endif
      end
   end

   // Only the ALL_ONE constant is unused when stuck detection is off.
   logic unused_ok;
   assign unused_ok = &{1'b0, ALL_ONE};

endmodule
